// File: rtl/ntt_core_param.sv
// ntt_core_param
//   Radix-2 in-place NTT / INTT engine over Z_Q. Butterfly addresses are
//   generated from stage/group/butterfly counters, so no address ROM is
//   needed. One single-port synchronous coefficient BRAM and one twiddle ROM
//   are driven from registered outputs. Both memories have a 1-cycle read
//   latency, so read data is valid two cycles after the state that issues the
//   address.
//
//   Optional build macro: NTT_INV_SCALE_EN
//     defined   : an INTT run ends with a scaling pass (SC_RD/SC_WAIT/SC_WR)
//                 that multiplies every coefficient by N_INV.
//     undefined : the scaling states do not exist and INTT output is N*x mod Q.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        run request, sampled only in IDLE
//   mode         0 = NTT, 1 = INTT, latched when start is accepted
//   busy         high from the cycle after start is accepted until done
//   done         1-cycle completion pulse, coincides with busy falling
//   coeff_addr   BRAM address (registered)
//   coeff_we     BRAM write enable (registered)
//   coeff_din    BRAM write data (registered)
//   coeff_dout   BRAM read data
//   twid_addr    twiddle ROM address (registered)
//   twid_data    twiddle ROM read data
//
// Handshake: start is looked at only while the FSM is in IDLE; start or mode
// activity during a run is ignored. done and the falling edge of busy happen
// in the same cycle, and a start presented in that cycle is accepted.
//
// Twiddle ROM layout: entries 0..N-2 are NTT twiddles, N-1..2N-3 are INTT
// twiddles. The pointer advances once per finished group and is only reloaded
// when a run starts.

module ntt_core_param #(
  parameter int N      = 256,
  parameter int LOGN   = 8,
  parameter int Q      = 7681,
  parameter int N_INV  = 7651,
  parameter int DATA_W = 16,
  parameter int TW_AW  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [LOGN-1:0]   coeff_addr,
  output logic              coeff_we,
  output logic [DATA_W-1:0] coeff_din,
  input  logic [DATA_W-1:0] coeff_dout,
  output logic [TW_AW-1:0]  twid_addr,
  input  logic [DATA_W-1:0] twid_data
);

  localparam int SW = $clog2(LOGN);
  localparam int PW = 2 * DATA_W;
  localparam logic [DATA_W:0] QE = (DATA_W + 1)'(Q);
  localparam logic [PW-1:0]   QP = PW'(Q);

  localparam bit PARAMS_OK = (N == (1 << LOGN)) && (N >= 4) &&
                             (Q < (1 << DATA_W)) &&
                             (((N * N_INV) % Q) == 1) &&
                             ((1 << TW_AW) >= 2 * (N - 1));
  if (!PARAMS_OK) begin : g_param_check
    $error("ntt_core_param: inconsistent parameter set");
  end

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, LD_A, LD_B, MUL, WR_A, WR_B, NEXT
`ifdef NTT_INV_SCALE_EN
    , SC_RD, SC_WAIT, SC_WR
`endif
  } state_t;

  // Modular helpers; all operands are expected to be < Q.
  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QE) s = s - QE;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [DATA_W:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + QE - {1'b0, y};
    return d[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mul_mod(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    logic [PW-1:0] p;
    logic [PW-1:0] r;
    p = PW'(x) * PW'(y);
    r = p % QP;
    return r[DATA_W-1:0];
  endfunction

  state_t            state, state_nx;
  logic              mode_r, mode_nx;
  logic [SW-1:0]     stage, stage_nx;
  logic [LOGN-1:0]   grp, grp_nx;
  logic [LOGN-1:0]   bfu, bfu_nx;      // butterfly index; coefficient index in the scaling pass
  logic [TW_AW-1:0]  ptr, ptr_nx;
  logic [DATA_W-1:0] reg_a, reg_a_nx;
  logic [DATA_W-1:0] reg_b, reg_b_nx;
  logic [DATA_W-1:0] reg_w, reg_w_nx;
  logic [DATA_W-1:0] reg_t, reg_t_nx;  // NTT: B*W ; INTT: A+B
  logic [DATA_W-1:0] reg_u, reg_u_nx;  // INTT: A-B
  logic              busy_nx, done_nx, we_nx;
  logic [LOGN-1:0]   addr_nx;
  logic [DATA_W-1:0] din_nx;
  logic [TW_AW-1:0]  tw_nx;

  // Butterfly geometry. lg = log2(len): NTT halves len every stage starting
  // at N/2, INTT doubles it starting at 1.
  logic [SW-1:0]   lg;
  logic [LOGN-1:0] len, grp_last, a_addr, b_addr;
  logic            bfu_done, grp_done, stage_done;

  assign lg         = mode_r ? stage : SW'(LOGN - 1) - stage;
  assign len        = LOGN'(1) << lg;
  assign grp_last   = (LOGN'(N / 2) >> lg) - LOGN'(1);
  assign a_addr     = ((grp << lg) << 1) + bfu;
  assign b_addr     = a_addr + len;
  assign bfu_done   = (bfu == len - LOGN'(1));
  assign grp_done   = (grp == grp_last);
  assign stage_done = (stage == SW'(LOGN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_r     <= 1'b0;
      stage      <= '0;
      grp        <= '0;
      bfu        <= '0;
      ptr        <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      reg_w      <= '0;
      reg_t      <= '0;
      reg_u      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      coeff_we   <= 1'b0;
      coeff_addr <= '0;
      coeff_din  <= '0;
      twid_addr  <= '0;
    end else begin
      state      <= state_nx;
      mode_r     <= mode_nx;
      stage      <= stage_nx;
      grp        <= grp_nx;
      bfu        <= bfu_nx;
      ptr        <= ptr_nx;
      reg_a      <= reg_a_nx;
      reg_b      <= reg_b_nx;
      reg_w      <= reg_w_nx;
      reg_t      <= reg_t_nx;
      reg_u      <= reg_u_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      coeff_we   <= we_nx;
      coeff_addr <= addr_nx;
      coeff_din  <= din_nx;
      twid_addr  <= tw_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mode_nx  = mode_r;
    stage_nx = stage;
    grp_nx   = grp;
    bfu_nx   = bfu;
    ptr_nx   = ptr;
    reg_a_nx = reg_a;
    reg_b_nx = reg_b;
    reg_w_nx = reg_w;
    reg_t_nx = reg_t;
    reg_u_nx = reg_u;
    busy_nx  = busy;
    done_nx  = 1'b0;
    we_nx    = 1'b0;
    addr_nx  = coeff_addr;
    din_nx   = coeff_din;
    tw_nx    = twid_addr;

    case (state)
      IDLE: begin
        if (start) begin
          mode_nx  = mode;
          stage_nx = '0;
          grp_nx   = '0;
          bfu_nx   = '0;
          ptr_nx   = mode ? TW_AW'(N - 1) : '0;
          busy_nx  = 1'b1;
          state_nx = RD_A;
        end
      end
      // NEXT is the first read cycle of every butterfly after the first one;
      // the counters already advanced when WR_B was left.
      RD_A, NEXT: begin
        addr_nx  = a_addr;
        tw_nx    = ptr;
        state_nx = RD_B;
      end
      RD_B: begin
        addr_nx  = b_addr;
        state_nx = LD_A;
      end
      LD_A: begin
        reg_a_nx = coeff_dout;
        state_nx = LD_B;
      end
      LD_B: begin
        reg_b_nx = coeff_dout;
        reg_w_nx = twid_data;   // twid_addr is still held from RD_A
        state_nx = MUL;
      end
      MUL: begin
        if (!mode_r) begin
          reg_t_nx = mul_mod(reg_b, reg_w);
        end else begin
          reg_t_nx = add_mod(reg_a, reg_b);
          reg_u_nx = sub_mod(reg_a, reg_b);
        end
        state_nx = WR_A;
      end
      WR_A: begin
        we_nx    = 1'b1;
        addr_nx  = a_addr;
        din_nx   = mode_r ? reg_t : add_mod(reg_a, reg_t);
        state_nx = WR_B;
      end
      WR_B: begin
        we_nx    = 1'b1;
        addr_nx  = b_addr;
        din_nx   = mode_r ? mul_mod(reg_u, reg_w) : sub_mod(reg_a, reg_t);
        state_nx = NEXT;
        if (!bfu_done) begin
          bfu_nx = bfu + LOGN'(1);
        end else begin
          bfu_nx = '0;
          ptr_nx = ptr + TW_AW'(1);
          if (!grp_done) begin
            grp_nx = grp + LOGN'(1);
          end else begin
            grp_nx = '0;
            if (!stage_done) begin
              stage_nx = stage + SW'(1);
            end else begin
`ifdef NTT_INV_SCALE_EN
              if (mode_r) begin
                state_nx = SC_RD;
              end else begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
              end
`else
              state_nx = IDLE;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef NTT_INV_SCALE_EN
      SC_RD: begin
        addr_nx  = bfu;
        state_nx = SC_WAIT;
      end
      SC_WAIT: begin
        state_nx = SC_WR;
      end
      SC_WR: begin
        we_nx  = 1'b1;
        din_nx = mul_mod(coeff_dout, DATA_W'(N_INV));
        if (bfu == LOGN'(N - 1)) begin
          bfu_nx   = '0;
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          bfu_nx   = bfu + LOGN'(1);
          state_nx = SC_RD;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ntt_core_param.sv
// tb_ntt_core_param
//   Directed/randomised bench for ntt_core_param at N=8, Q=7681. Holds a BRAM
//   and twiddle ROM model (1-cycle read latency) and a loop-based reference of
//   the transform. Works with or without NTT_INV_SCALE_EN.

module tb_ntt_core_param;

  localparam int N      = 8;
  localparam int LOGN   = 3;
  localparam int Q      = 7681;
  localparam int N_INV  = 6721;
  localparam int DATA_W = 16;
  localparam int TW_AW  = 4;
  localparam int BUDGET = 1000;

`ifdef NTT_INV_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif
  localparam int LAT_NTT  = 84;
  localparam int LAT_INTT = SCALE ? 108 : 84;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start, mode, busy, done, coeff_we;
  logic [LOGN-1:0]   coeff_addr;
  logic [DATA_W-1:0] coeff_din, coeff_dout;
  logic [TW_AW-1:0]  twid_addr;
  logic [DATA_W-1:0] twid_data;

  ntt_core_param #(
    .N(N), .LOGN(LOGN), .Q(Q), .N_INV(N_INV), .DATA_W(DATA_W), .TW_AW(TW_AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .coeff_addr(coeff_addr), .coeff_we(coeff_we), .coeff_din(coeff_din),
    .coeff_dout(coeff_dout), .twid_addr(twid_addr), .twid_data(twid_data)
  );

  // memory models
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] rom [1 << TW_AW];
  logic [DATA_W-1:0] mem_q, rom_q;
  logic              ld_we;
  logic [LOGN-1:0]   ld_addr;
  logic [DATA_W-1:0] ld_din;
  int                done_cnt = 0;

  always @(posedge clk) begin
    if (coeff_we)   mem[coeff_addr] <= coeff_din;
    else if (ld_we) mem[ld_addr] <= ld_din;
    mem_q <= mem[coeff_addr];
    rom_q <= rom[twid_addr];
    if (done) done_cnt <= done_cnt + 1;
  end
  assign coeff_dout = mem_q;
  assign twid_data  = rom_q;

  // scoreboard
  int checks   = 0;
  int failures = 0;
  int ref_v [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pow_mod(input int b, input int e);
    longint r = 1;
    longint x = longint'(b);
    int     k = e;
    while (k > 0) begin
      if ((k & 1) != 0) r = (r * x) % Q;
      x = (x * x) % Q;
      k = k >> 1;
    end
    return int'(r);
  endfunction

  // Reference transform: textbook loops over stage / group / butterfly.
  task automatic model_run(input logic m);
    int len, p, a, b, x, y, w, t;
    p = m ? N - 1 : 0;
    for (int s = 0; s < LOGN; s++) begin
      len = m ? (1 << s) : (N >> (s + 1));
      for (int g = 0; g < N / (2 * len); g++) begin
        w = int'(rom[p]);
        for (int j = 0; j < len; j++) begin
          a = g * 2 * len + j;
          b = a + len;
          x = ref_v[a];
          y = ref_v[b];
          if (!m) begin
            t = (y * w) % Q;
            ref_v[a] = (x + t) % Q;
            ref_v[b] = (x + Q - t) % Q;
          end else begin
            ref_v[a] = (x + y) % Q;
            ref_v[b] = (((x + Q - y) % Q) * w) % Q;
          end
        end
        p++;
      end
    end
    if (m && SCALE)
      for (int i = 0; i < N; i++) ref_v[i] = (ref_v[i] * N_INV) % Q;
  endtask

  // driver tasks
  task automatic load_ref();
    for (int i = 0; i < N; i++) begin
      ld_we   = 1'b1;
      ld_addr = LOGN'(i);
      ld_din  = DATA_W'(ref_v[i]);
      @(posedge clk); #1;
    end
    ld_we = 1'b0;
  endtask

  task automatic rand_ref();
    for (int i = 0; i < N; i++) ref_v[i] = int'($urandom_range(0, Q - 1));
  endtask

  // Start a run; returns at the cycle where done is seen (or budget expires).
  // poke != 0 pulses start with the opposite mode at that cycle of the run.
  task automatic run(input logic m, input int poke, output int lat);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    lat = 0;
    while (lat < BUDGET) begin
      if (poke != 0 && lat == poke) begin
        start = 1'b1;
        mode  = ~m;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    start = 1'b0;
    mode  = m;
    check("busy_low_at_done", busy, 0);
  endtask

  // One more cycle so the final write lands; done must be a single pulse.
  task automatic settle();
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(mem[i]), ref_v[i]);
  endtask

  int lat, off, ng, dc0;

  initial begin
    rst_n = 1'b1; start = 1'b0; mode = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_din = '0;

    // Twiddles: random nonzero NTT entries; each INTT entry is the inverse of
    // the NTT twiddle used on the same butterfly pairs.
    for (int i = 0; i < (1 << TW_AW); i++) rom[i] = '0;
    for (int i = 0; i < N - 1; i++) rom[i] = DATA_W'($urandom_range(1, Q - 1));
    off = N - 1;
    for (int s = 0; s < LOGN; s++) begin
      ng = N >> (s + 1);
      for (int g = 0; g < ng; g++)
        rom[off + g] = DATA_W'(pow_mod(int'(rom[ng - 1 + g]), Q - 2));
      off += ng;
    end

    // 1. reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", coeff_we, 0);
    check("rst_addr", 32'(coeff_addr), 0);
    check("rst_twid_addr", 32'(twid_addr), 0);
    check("rst_din", 32'(coeff_din), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 2. delta input -> all ones
    for (int i = 0; i < N; i++) ref_v[i] = (i == 0) ? 1 : 0;
    load_ref();
    run(1'b0, 0, lat);
    check("ntt_latency", lat, LAT_NTT);
    settle();
    for (int i = 0; i < N; i++) ref_v[i] = 1;
    compare_mem("delta_ntt");

    // 3/4. [1..8] NTT then INTT back-to-back
    for (int i = 0; i < N; i++) ref_v[i] = i + 1;
    load_ref();
    run(1'b0, 0, lat);
    check("ntt_latency_seq", lat, LAT_NTT);
    run(1'b1, 0, lat);
    check("intt_latency", lat, LAT_INTT);
    settle();
    for (int i = 0; i < N; i++) ref_v[i] = SCALE ? (i + 1) : ((N * (i + 1)) % Q);
    compare_mem("roundtrip");

    // 5. all inputs Q-1
    for (int i = 0; i < N; i++) ref_v[i] = Q - 1;
    load_ref();
    run(1'b0, 0, lat);
    settle();
    model_run(1'b0);
    compare_mem("maxin_ntt");
    for (int i = 0; i < N; i++) check("maxin_range", 32'(mem[i] < DATA_W'(Q)), 1);
    run(1'b1, 0, lat);
    settle();
    model_run(1'b1);
    compare_mem("maxin_intt");

    // random vectors in both modes
    for (int k = 0; k < 3; k++) begin
      rand_ref();
      load_ref();
      run(1'b0, 0, lat);
      check("rand_ntt_latency", lat, LAT_NTT);
      settle();
      model_run(1'b0);
      compare_mem("rand_ntt");
      rand_ref();
      load_ref();
      run(1'b1, 0, lat);
      check("rand_intt_latency", lat, LAT_INTT);
      settle();
      model_run(1'b1);
      compare_mem("rand_intt");
    end

    // 6. start pulse with flipped mode mid-run is ignored
    rand_ref();
    load_ref();
    run(1'b0, 20, lat);
    check("poke_latency", lat, LAT_NTT);
    settle();
    model_run(1'b0);
    compare_mem("poke_ntt");

    // reset at cycle 40 of a run aborts it
    rand_ref();
    load_ref();
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_we", coeff_we, 0);
    check("abort_addr", 32'(coeff_addr), 0);
    check("abort_twid_addr", 32'(twid_addr), 0);
    dc0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, dc0);
    check("abort_idle", busy, 0);
    rand_ref();
    load_ref();
    run(1'b1, 0, lat);
    check("after_abort_latency", lat, LAT_INTT);
    settle();
    model_run(1'b1);
    compare_mem("after_abort_intt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
